// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with stall hold, bubble insertion, flush
// and feedback of the multi-cycle EX accumulator/step count.
// Optional EX_MEM_BUBBLE_CNT_EN builds a saturating 32-bit bubble counter;
// without it bubble_cnt is constant 0.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_ex,
  input  logic                stall_mem,
  input  logic                flush,
  input  logic [REG_AW-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [REG_AW-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic [31:0]         bubble_cnt
);
  logic upd, adv, keep;
  assign upd  = flush | ~stall_mem;
  assign adv  = ~flush & ~stall_ex;
  assign keep = ~flush & stall_ex;
  // Pipeline register: flush/bubble load a NOP, advance copies EX, MEM stall holds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else if (upd) begin
      mem_wd       <= adv ? ex_wd : '0;
      mem_wreg     <= adv & ex_wreg;
      mem_wdata    <= adv ? ex_wdata : '0;
      mem_hi       <= adv ? ex_hi : '0;
      mem_lo       <= adv ? ex_lo : '0;
      mem_whilo    <= adv & ex_whilo;
      mem_aluop    <= adv ? ex_aluop : '0;
      mem_mem_addr <= adv ? ex_mem_addr : '0;
      mem_reg2     <= adv ? ex_reg2 : '0;
      hilo_o       <= keep ? hilo_i : '0;
      cnt_o        <= keep ? cnt_i : '0;
    end
`ifdef EX_MEM_BUBBLE_CNT_EN
  // Count bubble edges, saturating; only reset clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) bubble_cnt <= '0;
    else if (keep && !stall_mem && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
`else
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors with hand-computed expectations for ex_mem_stage
module tb_ex_mem_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        stall_ex = 0, stall_mem = 0, flush = 0;
  logic [4:0]  ex_wd = 0;
  logic        ex_wreg = 0, ex_whilo = 0;
  logic [31:0] ex_wdata = 0, ex_hi = 0, ex_lo = 0, ex_mem_addr = 0, ex_reg2 = 0;
  logic [7:0]  ex_aluop = 0;
  logic [63:0] hilo_i = 0;
  logic [1:0]  cnt_i = 0;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2, bubble_cnt;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  int checks = 0, failures = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, " wd"}, 64'(mem_wd), 0);
    chk({tag, " wreg"}, 64'(mem_wreg), 0);
    chk({tag, " wdata"}, 64'(mem_wdata), 0);
    chk({tag, " hi"}, 64'(mem_hi), 0);
    chk({tag, " lo"}, 64'(mem_lo), 0);
    chk({tag, " whilo"}, 64'(mem_whilo), 0);
    chk({tag, " aluop"}, 64'(mem_aluop), 0);
    chk({tag, " addr"}, 64'(mem_mem_addr), 0);
    chk({tag, " reg2"}, 64'(mem_reg2), 0);
  endtask

  task automatic load_instr(input logic [4:0] wd, input logic [31:0] wdata);
    ex_wd = wd; ex_wreg = 1; ex_wdata = wdata; ex_whilo = 1; ex_hi = 32'h1; ex_lo = 32'h2;
    ex_aluop = 8'hA3; ex_mem_addr = 32'h1000_0040; ex_reg2 = 32'hCAFE_0001;
  endtask

  initial begin
    step();
    chk_nop("reset");
    chk("reset hilo", hilo_o, 0);
    chk("reset cnt", 64'(cnt_o), 0);
    chk("reset bcnt", 64'(bubble_cnt), 0);
    rst = 0;
    // advance: EX fields reach MEM, feedback clears even with nonzero hilo_i/cnt_i
    load_instr(5'd3, 32'hDEADBEEF);
    hilo_i = 64'h5555_0000_0000_7777; cnt_i = 2'd3;
    step();
    chk("adv wd", 64'(mem_wd), 3);
    chk("adv wreg", 64'(mem_wreg), 1);
    chk("adv wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("adv hi", 64'(mem_hi), 1);
    chk("adv lo", 64'(mem_lo), 2);
    chk("adv whilo", 64'(mem_whilo), 1);
    chk("adv aluop", 64'(mem_aluop), 64'hA3);
    chk("adv addr", 64'(mem_mem_addr), 64'h1000_0040);
    chk("adv reg2", 64'(mem_reg2), 64'hCAFE_0001);
    chk("adv hilo", hilo_o, 0);
    chk("adv cnt", 64'(cnt_o), 0);
    // multi-cycle madd: two bubbles feeding back accumulator, then advance
    ex_wd = 5'd0; ex_wreg = 0; ex_whilo = 1; ex_hi = 32'hAAAA_0001; ex_lo = 32'hBBBB_0002;
    ex_aluop = 8'h14; stall_ex = 1;
    hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    step();
    chk_nop("mc1");
    chk("mc1 cnt", 64'(cnt_o), 1);
    chk("mc1 hilo", hilo_o, 64'h0000_0001_0000_0002);
    hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'd2;
    step();
    chk_nop("mc2");
    chk("mc2 cnt", 64'(cnt_o), 2);
    chk("mc2 hilo", hilo_o, 64'h0000_0003_0000_0004);
    stall_ex = 0;
    step();
    chk("mc adv cnt", 64'(cnt_o), 0);
    chk("mc adv hilo", hilo_o, 0);
    chk("mc adv whilo", 64'(mem_whilo), 1);
    chk("mc adv wreg", 64'(mem_wreg), 0);
    chk("mc adv hi", 64'(mem_hi), 64'hAAAA_0001);
    chk("mc adv lo", 64'(mem_lo), 64'hBBBB_0002);
    chk("mc adv aluop", 64'(mem_aluop), 64'h14);
    // full hold with changing inputs
    load_instr(5'd9, 32'h12345678);
    step();
    chk("hold load", 64'(mem_wdata), 64'h12345678);
    stall_ex = 1; stall_mem = 1;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h9000_0000 + i; ex_wd = 5'(i); hilo_i = 64'(i + 7); cnt_i = 2'(i + 1);
      step();
      chk("hold wdata", 64'(mem_wdata), 64'h12345678);
      chk("hold wd", 64'(mem_wd), 9);
      chk("hold wreg", 64'(mem_wreg), 1);
      chk("hold hilo", hilo_o, 0);
      chk("hold cnt", 64'(cnt_o), 0);
    end
    // flush beats MEM stall while MEM holds a live write
    flush = 1;
    step();
    chk_nop("flush live");
    flush = 0;
    // hold nonzero feedback, then flush it away under a MEM stall
    stall_mem = 0; hilo_i = 64'h0000_00FF_0000_0011; cnt_i = 2'd2;
    step();
    chk("pre cnt", 64'(cnt_o), 2);
    stall_mem = 1; cnt_i = 2'd3; hilo_i = 64'h1;
    step();
    chk("hold fb cnt", 64'(cnt_o), 2);
    chk("hold fb hilo", hilo_o, 64'h0000_00FF_0000_0011);
    flush = 1;
    step();
    chk("flush cnt", 64'(cnt_o), 0);
    chk("flush hilo", hilo_o, 0);
    chk_nop("flush stall");
    flush = 0; stall_ex = 0; stall_mem = 0;
    // asynchronous reset between edges
    load_instr(5'd17, 32'h0BAD_F00D);
    step();
    chk("pre rst wd", 64'(mem_wd), 17);
    stall_ex = 1; hilo_i = 64'h42; cnt_i = 2'd1;
    step();
    chk("pre rst cnt", 64'(cnt_o), 1);
    stall_ex = 0;
    step();
    #2 rst = 1;
    #1;
    chk_nop("async rst");
    chk("async rst hilo", hilo_o, 0);
    chk("async rst cnt", 64'(cnt_o), 0);
    chk("async rst bcnt", 64'(bubble_cnt), 0);
    step();
    chk_nop("rst held");
    chk("rst held cnt", 64'(cnt_o), 0);
    rst = 0;
    // counter: 5 bubbles, 2 holds, 1 flush
    stall_ex = 1;
    repeat (5) step();
    stall_mem = 1;
    repeat (2) step();
    flush = 1;
    step();
    flush = 0; stall_ex = 0; stall_mem = 0;
    step();
`ifdef EX_MEM_BUBBLE_CNT_EN
    chk("bubble cnt", 64'(bubble_cnt), 5);
`else
    chk("bubble cnt", 64'(bubble_cnt), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised successor of the EX/MEM pipeline register in the five-stage MIPS core.
- Carries register writeback, HI/LO writeback and load/store fields from EX to MEM.
- Adds stall handling, bubble insertion and flush.
- Preserves multi-cycle EX state (madd/msub accumulator temp, cycle count) across EX stalls and feeds it back to EX.

Parameters:
- DATA_W, 32, width of data words, HI/LO, addresses and store data
- REG_AW, 5, register-file address width
- ALUOP_W, 8, ALU opcode width forwarded to MEM
- CNT_W, 2, width of the multi-cycle step counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_ex  in  1  EX stage stalled this cycle
- stall_mem  in  1  MEM stage stalled this cycle
- flush  in  1  exception flush; kill the EX/MEM contents
- ex_wd  in  REG_AW  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  result data
- ex_hi, ex_lo  in  DATA_W  HI/LO write values
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  opcode for MEM load/store decode
- ex_mem_addr  in  DATA_W  effective address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  EX partial accumulator
- cnt_i  in  CNT_W  EX multi-cycle step
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  (widths match the inputs)  registered copies to MEM
- hilo_o  out  2*DATA_W  accumulator returned to EX
- cnt_o  out  CNT_W  step count returned to EX
- bubble_cnt  out  32  bubble counter (see Optional Feature)

Behaviour:
- All outputs are registers.
- Reset: asynchronous, active-high. While rst=1, every output is 0, including mem_wd (NOP address 0), mem_wreg=0, mem_whilo=0, hilo_o=0, cnt_o=0, bubble_cnt=0.
- Per rising clk edge when rst=0, first matching rule wins:
  1. flush=1: all mem_* outputs cleared to 0; hilo_o=0; cnt_o=0. Overrides any stall.
  2. stall_mem=1: all outputs hold, including hilo_o/cnt_o. This applies to both stall_ex=1 and the illegal stall_ex=0 combination.
  3. stall_ex=1 and stall_mem=0 (bubble): all mem_* outputs cleared to 0, so MEM sees a NOP. hilo_o<=hilo_i, cnt_o<=cnt_i.
  4. otherwise (advance): every mem_* output <= matching ex_* input; hilo_o<=0; cnt_o<=0.
- Latency: one cycle EX to MEM. No combinational input-to-output path.
- Multi-cycle contract: during a madd/msub stall sequence, EX drives hilo_i/cnt_i each cycle and sees them on hilo_o/cnt_o one cycle later. On advance, both clear so the next instruction starts from cnt=0.
- Reset mid-sequence: an asynchronous assertion clears hilo_o/cnt_o immediately. A partial accumulator is never retained across reset or flush.
- Bubble outputs must have mem_wreg=0 and mem_whilo=0 so forwarding logic ignores them. Data fields are also zeroed for deterministic waveforms.
- No wrap-around: cnt_o is a plain copy of cnt_i; overflow is EX's responsibility.

Optional Feature:
- Macro: EX_MEM_BUBBLE_CNT_EN.
- With the macro defined: bubble_cnt is a 32-bit counter.
  - Increments by 1 on each rule-3 (bubble) edge.
  - Saturates at 0xFFFFFFFF.
  - Holds on rules 2 and 4.
  - Cleared by rst only; flush does not clear it.
- Without the macro: bubble_cnt is tied to constant 0 and no counter flops are built.

Test Plan:
- Reset: assert rst asynchronously between edges with non-zero inputs -> all outputs 0 immediately, before the next edge; stay 0 while rst=1.
- Advance: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2, stalls 0 -> next edge mem_wd=3, mem_wdata=DEADBEEF, mem_hi=1, mem_lo=2, mem_whilo=1; hilo_o=0, cnt_o=0.
- Multi-cycle: stall_ex=1, stall_mem=0 for 2 cycles with hilo_i=64'h0000_0001_0000_0002, cnt_i=1 then cnt_i=2 -> mem_wreg=0, mem_whilo=0 both cycles; cnt_o=1 then 2; hilo_o tracks hilo_i; then advance -> cnt_o=0, mem_* carry the madd fields.
- Full hold: load mem_wdata=32'h12345678, then stall_ex=1, stall_mem=1 for 3 cycles with changing inputs -> mem_wdata stays 12345678 and hilo_o/cnt_o unchanged.
- Flush priority: flush=1 together with stall_mem=1, while mem_wreg=1 and cnt_o=2 -> next edge every mem_* output is 0 and cnt_o=0.
- Counter (macro on): 5 bubble edges, 2 hold edges, 1 flush -> bubble_cnt=5; with the macro off, bubble_cnt=0 throughout.
